alu_cmd_sequencer: RTL

- Command front-end directly upstream of the 8-bit accumulator ALU.
- Buffers ALU commands in a small FIFO behind a valid/ready handshake.
- Issues one command at a time as one-hot in_selector/out_selector plus operands, samples the ALU result and overflow after a fixed latency, and returns a single-cycle response.
- Locks into an error state on ALU overflow until software clears it.

---
 rtl/alu_pkg.sv | 70 +++++++
 rtl/alu_cmd_fifo.sv | 50 +++++
 rtl/alu_cmd_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: command codes, state
// encodings, one-hot selector widths, decode helpers and the idle drive pattern.
package alu_pkg;

  localparam int OP_W      = 3;
  localparam int SRC_W     = 2;
  localparam int DATA_W    = 8;
  localparam int IN_SEL_W  = 3;
  localparam int OUT_SEL_W = 7;
  localparam int ENTRY_W   = OP_W + SRC_W + 2 * DATA_W;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd3;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd4;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd5;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  localparam logic [SRC_W-1:0] SRC_PERSIST = 2'd0;
  localparam logic [SRC_W-1:0] SRC_LOAD    = 2'd1;
  localparam logic [SRC_W-1:0] SRC_CLEAR   = 2'd2;
  localparam logic [SRC_W-1:0] SRC_RSVD    = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ISSUE = 2'b01;
  localparam logic [1:0] S_WAIT  = 2'b10;
  localparam logic [1:0] S_ERROR = 2'b11;

  // Accumulator AND 8'hFF leaves the accumulator untouched.
  localparam logic [IN_SEL_W-1:0]  IDLE_IN_SEL  = 3'b001;
  localparam logic [OUT_SEL_W-1:0] IDLE_OUT_SEL = 7'b0000001;
  localparam logic [DATA_W-1:0]    IDLE_NUM1    = 8'h00;
  localparam logic [DATA_W-1:0]    IDLE_NUM2    = 8'hFF;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] num1;
    logic [DATA_W-1:0] num2;
  } cmd_t;

  function automatic logic [OUT_SEL_W-1:0] op_onehot(input logic [OP_W-1:0] op);
    logic [OUT_SEL_W-1:0] oh;
    case (op)
      OP_AND:  oh = 7'b0000001;
      OP_OR:   oh = 7'b0000010;
      OP_XOR:  oh = 7'b0000100;
      OP_NOT:  oh = 7'b0001000;
      OP_ADD:  oh = 7'b0010000;
      OP_SUB:  oh = 7'b0100000;
      OP_MUL:  oh = 7'b1000000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  function automatic logic [IN_SEL_W-1:0] src_onehot(input logic [SRC_W-1:0] src);
    logic [IN_SEL_W-1:0] oh;
    case (src)
      SRC_PERSIST: oh = 3'b001;
      SRC_LOAD:    oh = 3'b010;
      SRC_CLEAR:   oh = 3'b100;
      default:     oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read behind a non-empty flag.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit accumulator ALU: FIFO, one-at-a-time issue, response.
// Optional ALU_SEQ_STATS_EN adds saturating done/error counters on stat_done/stat_err.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [SRC_W-1:0]     cmd_src,
  input  logic [DATA_W-1:0]    cmd_num1,
  input  logic [DATA_W-1:0]    cmd_num2,
  output logic [IN_SEL_W-1:0]  alu_in_selector,
  output logic [OUT_SEL_W-1:0] alu_out_selector,
  output logic [DATA_W-1:0]    alu_num1,
  output logic [DATA_W-1:0]    alu_num2,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_error,
  input  logic                 err_clear,
  output logic                 busy,
  output logic [15:0]          stat_done,
  output logic [15:0]          stat_err
);

  logic [1:0]           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [IN_SEL_W-1:0]  in_sel_q, in_sel_d;
  logic [OUT_SEL_W-1:0] out_sel_q, out_sel_d;
  logic [DATA_W-1:0]    num1_q, num1_d;
  logic [DATA_W-1:0]    num2_q, num2_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_rdata;
  cmd_t                 head;
  logic                 head_rsvd;

  assign cmd_ready = !fifo_full && (state_q != S_ERROR);
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
  assign head      = cmd_t'(fifo_rdata);
  assign head_rsvd = (head.op == OP_RSVD) || (head.src == SRC_RSVD);

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({cmd_op, cmd_src, cmd_num1, cmd_num2}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_sel_d    = in_sel_q;
    out_sel_d   = out_sel_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head_rsvd) begin
            // Reserved codes are answered directly and never reach the ALU.
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = S_ISSUE;
            in_sel_d  = src_onehot(head.src);
            out_sel_d = op_onehot(head.op);
            num1_d    = head.num1;
            num2_d    = head.num2;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 3'(ALU_LATENCY);
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_result;
          rsp_err_d   = alu_overflow;
          state_d     = alu_overflow ? S_ERROR : S_IDLE;
          in_sel_d    = IDLE_IN_SEL;
          out_sel_d   = IDLE_OUT_SEL;
          num1_d      = IDLE_NUM1;
          num2_d      = IDLE_NUM2;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        if (err_clear) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_sel_q    <= IDLE_IN_SEL;
      out_sel_q   <= IDLE_OUT_SEL;
      num1_q      <= IDLE_NUM1;
      num2_q      <= IDLE_NUM2;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_sel_q    <= in_sel_d;
      out_sel_q   <= out_sel_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_in_selector  = in_sel_q;
  assign alu_out_selector = out_sel_q;
  assign alu_num1         = num1_q;
  assign alu_num2         = num2_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_error        = rsp_err_q;
  assign busy             = !((state_q == S_IDLE) && fifo_empty);

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] done_q, done_d;
  logic [15:0] errc_q, errc_d;

  always_comb begin
    done_d = done_q;
    errc_d = errc_q;
    if (rsp_valid_q) begin
      if (done_q != 16'hFFFF) done_d = done_q + 16'd1;
      if (rsp_err_q && (errc_q != 16'hFFFF)) errc_d = errc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      errc_q <= '0;
    end else begin
      done_q <= done_d;
      errc_q <= errc_d;
    end
  end

  assign stat_done = done_q;
  assign stat_err  = errc_q;
`else
  assign stat_done = '0;
  assign stat_err  = '0;
`endif

endmodule
